// File: rtl/dlsc_axi_regslave.sv
// AXI slave terminating INCR bursts into a REGS x DATA register array.
// Optional DLSC_AXI_REGSLAVE_WLAST_CHECK_EN flags w_last/beat-count mismatch as SLVERR.
module dlsc_axi_regslave #(
    parameter int DATA = 32,
    parameter int ADDR = 32,
    parameter int LEN  = 4,
    parameter int RESP = 2,
    parameter int REGS = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              ar_ready,
    input  logic              ar_valid,
    input  logic [ADDR-1:0]   ar_addr,
    input  logic [LEN-1:0]    ar_len,
    input  logic              r_ready,
    output logic              r_valid,
    output logic              r_last,
    output logic [DATA-1:0]   r_data,
    output logic [RESP-1:0]   r_resp,
    output logic              aw_ready,
    input  logic              aw_valid,
    input  logic [ADDR-1:0]   aw_addr,
    input  logic [LEN-1:0]    aw_len,
    output logic              w_ready,
    input  logic              w_valid,
    input  logic              w_last,
    input  logic [DATA-1:0]   w_data,
    input  logic [DATA/8-1:0] w_strb,
    input  logic              b_ready,
    output logic              b_valid,
    output logic [RESP-1:0]   b_resp
);
    localparam int SB = DATA / 8;
    localparam int OB = $clog2(SB);
    localparam int IB = $clog2(REGS);
    localparam logic [RESP-1:0] OKAY   = '0;
    localparam logic [RESP-1:0] SLVERR = RESP'(2);

    typedef enum logic { RD_IDLE, RD_DATA } rd_state_t;
    typedef enum logic [1:0] { WR_IDLE, WR_DATA, WR_RESP } wr_state_t;

    rd_state_t rd_state_q, rd_state_d;
    wr_state_t wr_state_q, wr_state_d;

    logic [DATA-1:0] regs_q [REGS];
    logic [DATA-1:0] regs_d [REGS];

    logic [IB-1:0]   rd_idx_q, rd_idx_d;
    logic [LEN-1:0]  rd_cnt_q, rd_cnt_d;
    logic [LEN-1:0]  rd_len_q, rd_len_d;
    logic            rd_err_q, rd_err_d;
    logic [DATA-1:0] r_data_q, r_data_d;
    logic [RESP-1:0] r_resp_q, r_resp_d;
    logic            r_last_q, r_last_d;

    logic [IB-1:0]   wr_idx_q, wr_idx_d;
    logic [LEN-1:0]  wr_cnt_q, wr_cnt_d;
    logic [LEN-1:0]  wr_len_q, wr_len_d;
    logic            wr_err_q, wr_err_d;
    logic [RESP-1:0] b_resp_q, b_resp_d;
    logic            wr_bad;
`ifdef DLSC_AXI_REGSLAVE_WLAST_CHECK_EN
    logic            wl_err_q, wl_err_d;
`endif

    // Only the start address is range-checked; beats beyond it wrap.
    logic [IB-1:0] ar_idx, aw_idx;
    logic          ar_oor, aw_oor;
    logic          unused_ok;

    assign ar_idx = ar_addr[OB +: IB];
    assign aw_idx = aw_addr[OB +: IB];
    assign ar_oor = |ar_addr[ADDR-1:OB+IB];
    assign aw_oor = |aw_addr[ADDR-1:OB+IB];
`ifdef DLSC_AXI_REGSLAVE_WLAST_CHECK_EN
    assign unused_ok = ^{ar_addr[OB-1:0], aw_addr[OB-1:0]};
`else
    assign unused_ok = ^{ar_addr[OB-1:0], aw_addr[OB-1:0], w_last};
`endif

    assign ar_ready = (rd_state_q == RD_IDLE);
    assign r_valid  = (rd_state_q == RD_DATA);
    assign r_data   = r_data_q;
    assign r_resp   = r_resp_q;
    assign r_last   = r_last_q;
    assign aw_ready = (wr_state_q == WR_IDLE);
    assign w_ready  = (wr_state_q == WR_DATA);
    assign b_valid  = (wr_state_q == WR_RESP);
    assign b_resp   = b_resp_q;

    // Reads sample regs_q, so a same-cycle write is not yet visible.
    always_comb begin
        rd_state_d = rd_state_q;
        rd_idx_d   = rd_idx_q;
        rd_cnt_d   = rd_cnt_q;
        rd_len_d   = rd_len_q;
        rd_err_d   = rd_err_q;
        r_data_d   = r_data_q;
        r_resp_d   = r_resp_q;
        r_last_d   = r_last_q;
        unique case (rd_state_q)
            RD_IDLE: if (ar_valid) begin
                rd_state_d = RD_DATA;
                rd_err_d   = ar_oor;
                rd_len_d   = ar_len;
                rd_cnt_d   = '0;
                rd_idx_d   = ar_idx + IB'(1);
                r_data_d   = ar_oor ? '0 : regs_q[ar_idx];
                r_resp_d   = ar_oor ? SLVERR : OKAY;
                r_last_d   = (ar_len == '0);
            end
            RD_DATA: if (r_ready) begin
                if (r_last_q) begin
                    rd_state_d = RD_IDLE;
                    r_last_d   = 1'b0;
                end else begin
                    rd_cnt_d = rd_cnt_q + LEN'(1);
                    rd_idx_d = rd_idx_q + IB'(1);
                    r_data_d = rd_err_q ? '0 : regs_q[rd_idx_q];
                    r_resp_d = rd_err_q ? SLVERR : OKAY;
                    r_last_d = ((rd_cnt_q + LEN'(1)) == rd_len_q);
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        wr_state_d = wr_state_q;
        wr_idx_d   = wr_idx_q;
        wr_cnt_d   = wr_cnt_q;
        wr_len_d   = wr_len_q;
        wr_err_d   = wr_err_q;
        b_resp_d   = b_resp_q;
        wr_bad     = wr_err_q;
        regs_d     = regs_q;
`ifdef DLSC_AXI_REGSLAVE_WLAST_CHECK_EN
        wl_err_d   = wl_err_q;
`endif
        unique case (wr_state_q)
            WR_IDLE: if (aw_valid) begin
                wr_state_d = WR_DATA;
                wr_err_d   = aw_oor;
                wr_len_d   = aw_len;
                wr_cnt_d   = '0;
                wr_idx_d   = aw_idx;
`ifdef DLSC_AXI_REGSLAVE_WLAST_CHECK_EN
                wl_err_d   = 1'b0;
`endif
            end
            WR_DATA: if (w_valid) begin
                if (!wr_err_q) begin
                    for (int b = 0; b < SB; b++) begin
                        if (w_strb[b]) regs_d[wr_idx_q][b*8 +: 8] = w_data[b*8 +: 8];
                    end
                end
                wr_idx_d = wr_idx_q + IB'(1);
                wr_cnt_d = wr_cnt_q + LEN'(1);
`ifdef DLSC_AXI_REGSLAVE_WLAST_CHECK_EN
                if (w_last != (wr_cnt_q == wr_len_q)) wl_err_d = 1'b1;
                wr_bad = wr_err_q | wl_err_d;
`endif
                if (wr_cnt_q == wr_len_q) begin
                    wr_state_d = WR_RESP;
                    b_resp_d   = wr_bad ? SLVERR : OKAY;
                end
            end
            WR_RESP: if (b_ready) wr_state_d = WR_IDLE;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < REGS; i++) regs_q[i] <= '0;
            rd_state_q <= RD_IDLE;
            rd_idx_q   <= '0;
            rd_cnt_q   <= '0;
            rd_len_q   <= '0;
            rd_err_q   <= 1'b0;
            r_data_q   <= '0;
            r_resp_q   <= '0;
            r_last_q   <= 1'b0;
            wr_state_q <= WR_IDLE;
            wr_idx_q   <= '0;
            wr_cnt_q   <= '0;
            wr_len_q   <= '0;
            wr_err_q   <= 1'b0;
            b_resp_q   <= '0;
`ifdef DLSC_AXI_REGSLAVE_WLAST_CHECK_EN
            wl_err_q   <= 1'b0;
`endif
        end else begin
            for (int i = 0; i < REGS; i++) regs_q[i] <= regs_d[i];
            rd_state_q <= rd_state_d;
            rd_idx_q   <= rd_idx_d;
            rd_cnt_q   <= rd_cnt_d;
            rd_len_q   <= rd_len_d;
            rd_err_q   <= rd_err_d;
            r_data_q   <= r_data_d;
            r_resp_q   <= r_resp_d;
            r_last_q   <= r_last_d;
            wr_state_q <= wr_state_d;
            wr_idx_q   <= wr_idx_d;
            wr_cnt_q   <= wr_cnt_d;
            wr_len_q   <= wr_len_d;
            wr_err_q   <= wr_err_d;
            b_resp_q   <= b_resp_d;
`ifdef DLSC_AXI_REGSLAVE_WLAST_CHECK_EN
            wl_err_q   <= wl_err_d;
`endif
        end
    end

endmodule

// File: doc/dlsc_axi_regslave.md
DLSC_AXI_REGSLAVE -- requirements
Module: dlsc_axi_regslave

Interface
REQ-001 Parameter DATA, default 32, data width in bits (multiple of 8, power of 2).
REQ-002 Parameter ADDR, default 32, byte address width.
REQ-003 Parameter LEN, default 4, burst length field width (beats = len+1).
REQ-004 Parameter RESP, default 2, response width.
REQ-005 Parameter REGS, default 16, register count (power of 2, >=2).
REQ-006 Ports: clk input 1, sole clock; rst_n input 1, reset is asynchronous and active-low.
REQ-007 Read command: ar_ready output 1; ar_valid input 1; ar_addr input ADDR; ar_len input LEN.
REQ-008 Read data: r_ready input 1; r_valid output 1; r_last output 1; r_data output DATA; r_resp output RESP.
REQ-009 Write command: aw_ready output 1; aw_valid input 1; aw_addr input ADDR; aw_len input LEN.
REQ-010 Write data: w_ready output 1; w_valid input 1; w_last input 1; w_data input DATA; w_strb input DATA/8.
REQ-011 Write response: b_ready input 1; b_valid output 1; b_resp output RESP.

Function
REQ-012 Block SHALL act as AXI slave terminating INCR bursts into a REGS x DATA register array.
REQ-013 Register index SHALL be addr[log2(DATA/8) +: log2(REGS)]; low byte-offset bits ignored.
REQ-014 Burst SHALL be in-range iff start addr < REGS*(DATA/8); range checked on start address only.
REQ-015 Beat index SHALL increment by 1 per beat, wrapping modulo REGS.
REQ-016 Read FSM states RD_IDLE, RD_DATA; ar_ready=1 only in RD_IDLE; ar handshake -> RD_DATA next cycle.
REQ-017 r_valid SHALL assert the cycle after ar handshake (1-cycle latency) and stay high through RD_DATA.
REQ-018 r_data/r_resp/r_last SHALL hold stable while r_valid && !r_ready.
REQ-019 In-range read: r_data = register value at beat index, r_resp=2'b00; out-of-range: r_data=0, r_resp=2'b10 for every beat.
REQ-020 r_last SHALL be 1 on beat len only; handshake on last beat -> RD_IDLE.
REQ-021 Write FSM states WR_IDLE, WR_DATA, WR_RESP; aw_ready=1 only in WR_IDLE; w_ready=1 only in WR_DATA; b_valid=1 only in WR_RESP.
REQ-022 Write burst SHALL end after len+1 w handshakes (beat counter), then WR_RESP; b handshake -> WR_IDLE.
REQ-023 Each in-range w handshake SHALL update only bytes with w_strb set; out-of-range beats SHALL not modify registers.
REQ-024 b_resp SHALL be 2'b00 in-range, 2'b10 out-of-range.
REQ-025 Read and write paths SHALL be independent and concurrent.
REQ-026 Same-cycle write beat and read-data capture of same register: read SHALL return pre-write value.
REQ-027 Read data SHALL be captured into r_data register when entering each beat (after ar or r handshake), not combinational.
REQ-028 len=0 bursts SHALL be single-beat with r_last=1 on first beat.

Reset
REQ-029 On rst_n=0 (async): both FSMs IDLE, ar_ready=1, aw_ready=1, w_ready=0, r_valid=0, r_last=0, r_data=0, r_resp=0, b_valid=0, b_resp=0, counters 0.
REQ-030 Register array SHALL reset to all zeros.
REQ-031 Reset mid-burst SHALL abort the burst with no response; deassertion returns to IDLE state values above.

Configuration
REQ-032 Macro DLSC_AXI_REGSLAVE_WLAST_CHECK_EN, when defined: w_last mismatch with beat count (early or missing) sets sticky error, forcing b_resp=2'b10 for that burst; register writes still occur.
REQ-033 Without DLSC_AXI_REGSLAVE_WLAST_CHECK_EN: w_last SHALL be ignored; burst termination by count only.

Verification
REQ-034 Write aw_addr=0x8, aw_len=1, data 0x11111111/0x22222222, strb 0xF -> b_resp=00; regs[2]=0x11111111, regs[3]=0x22222222.
REQ-035 Read ar_addr=0x8, ar_len=1 after REQ-034 -> beats 0x11111111, 0x22222222, r_last on beat 2, r_resp=00, first r_valid 1 cycle after ar handshake.
REQ-036 Write aw_addr=0x3C, len=1 -> beats to regs[15] then regs[0] (wrap); readback ar_addr=0x3C,len=1 matches.
REQ-037 Read ar_addr=0x40, len=2 -> 3 beats r_data=0, r_resp=10; write aw_addr=0x40 -> b_resp=10, array unchanged.
REQ-038 Strobe 0x5 write of 0xAABBCCDD to reg0=0 -> reg0=0x00BB00DD; r_ready held low 5 cycles -> r_data stable.
REQ-039 rst_n pulsed low mid write burst (beat 1 of 4) -> outputs per REQ-029 immediately, array zero, next burst completes normally; with WLAST_CHECK_EN, w_last on beat 0 of len=1 -> b_resp=10.
